// File: rtl/ex_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// Fixed 33-cycle latency: 32 shift-add/shift-subtract steps plus a sign-fix cycle.
module ex_muldiv_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        flush,
    input  logic        mthi,
    input  logic        mtlo,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  op_q, op_d;
    logic [31:0] opnd_q, opnd_d;
    logic [31:0] raw_a_q, raw_a_d;
    logic [63:0] acc_q, acc_d;
    logic [5:0]  cnt_q, cnt_d;
    logic        neg_res_q, neg_res_d;
    logic        neg_rem_q, neg_rem_d;
    logic        div0_q, div0_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        done_q, done_d;
    logic        busy_q, busy_d;

    logic        is_signed_s;
    logic [31:0] mag_a_s, mag_b_s;
    logic [32:0] sum_s;
    logic [32:0] diff_s;
    logic [63:0] mul_step_s;
    logic [63:0] div_step_s;
    logic [63:0] prod_s;

    function automatic logic [31:0] abs32(input logic [31:0] x, input logic sgn);
        if (sgn && x[31]) begin
            abs32 = 32'd0 - x;
        end else begin
            abs32 = x;
        end
    endfunction

    function automatic logic [31:0] cond_neg32(input logic [31:0] x, input logic neg);
        if (neg) begin
            cond_neg32 = 32'd0 - x;
        end else begin
            cond_neg32 = x;
        end
    endfunction

    // Next-state, datapath step and HI/LO update.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        opnd_d    = opnd_q;
        raw_a_d   = raw_a_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        div0_d    = div0_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;

        is_signed_s = ~op[0];
        mag_a_s     = abs32(src_a, is_signed_s);
        mag_b_s     = abs32(src_b, is_signed_s);

        // Remainder stays below the divisor, so diff_s[32] is a clean borrow flag.
        sum_s      = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
        mul_step_s = {sum_s, acc_q[31:1]};
        diff_s     = acc_q[63:31] - {1'b0, opnd_q};
        div_step_s = diff_s[32] ? {acc_q[62:0], 1'b0} : {diff_s[31:0], acc_q[30:0], 1'b1};
        prod_s     = neg_res_q ? (64'd0 - acc_q) : acc_q;

        case (state_q)
            S_IDLE: begin
                if (start && !flush) begin
                    op_d      = op;
                    opnd_d    = op[1] ? mag_b_s : mag_a_s;
                    acc_d     = op[1] ? {32'd0, mag_a_s} : {32'd0, mag_b_s};
                    raw_a_d   = src_a;
                    neg_res_d = is_signed_s & (src_a[31] ^ src_b[31]);
                    neg_rem_d = is_signed_s & src_a[31];
                    div0_d    = (src_b == 32'd0);
                    cnt_d     = 6'd0;
                    state_d   = S_CALC;
                end else if (!start) begin
                    hi_d = mthi ? src_a : hi_q;
                    lo_d = mtlo ? src_a : lo_q;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CALC: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    acc_d   = op_q[1] ? div_step_s : mul_step_s;
                    cnt_d   = cnt_q + 6'd1;
                    state_d = (cnt_q == 6'd31) ? S_FIX : S_CALC;
                end
            end
            S_FIX: begin
                state_d = S_IDLE;
                if (flush) begin
                    done_d = 1'b0;
                end else if (!op_q[1]) begin
                    done_d = 1'b1;
                    hi_d   = prod_s[63:32];
                    lo_d   = prod_s[31:0];
                end else if (div0_q) begin
                    done_d = 1'b1;
                    hi_d   = raw_a_q;
                    lo_d   = 32'hFFFF_FFFF;
                end else begin
                    done_d = 1'b1;
                    hi_d   = cond_neg32(acc_q[63:32], neg_rem_q);
                    lo_d   = cond_neg32(acc_q[31:0], neg_res_q);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            op_q      <= 2'd0;
            opnd_q    <= 32'd0;
            raw_a_q   <= 32'd0;
            acc_q     <= 64'd0;
            cnt_q     <= 6'd0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            div0_q    <= 1'b0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            opnd_q    <= opnd_d;
            raw_a_q   <= raw_a_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            div0_q    <= div0_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
        end
    end

    assign hi   = hi_q;
    assign lo   = lo_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule
